// File: rtl/memaccess_unit.sv
// rtl/memaccess_unit.sv - LC-3 memory-access stage: sequences direct/indirect loads and stores onto the data-memory port
//
// Purpose: accepts one load/store request at a time over req_valid/req_ready,
// walks the data-memory port through pointer fetch, data fetch and write
// phases, and returns the load data (or a write completion) over
// rsp_valid/rsp_ready. Memory reads take RD_LAT cycles (1..8).
//
// Ports:
//   clock, reset            clock; asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op                  00 READ, 01 READ_INDIR, 10 WRITE, 11 WRITE_INDIR
//   req_addr, req_data      effective address and store data
//   rsp_valid/rsp_ready     response handshake
//   memout                  load data, 0 after a write
//   busy                    high in every state except IDLE
//   DMem_en/DMem_rd         access strobe, 1 = read / 0 = write
//   DMem_addr/DMem_din      memory address and write data
//   DMem_dout               memory read data
//
// Build option: MEMACCESS_TRISTATE_EN releases DMem_addr, DMem_din and DMem_rd
// to z whenever the unit is not accessing memory (shared bus); otherwise
// they are driven 0 at those times.

module memaccess_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] memout,
    output logic              busy,
    output logic              DMem_en,
    output logic              DMem_rd,
    output logic [ADDR_W-1:0] DMem_addr,
    output logic [DATA_W-1:0] DMem_din,
    input  logic [DATA_W-1:0] DMem_dout
);

    generate
        if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
            $error("memaccess_unit: RD_LAT must be in 1..8");
        end
    endgenerate

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_PTR,
        RD_DATA,
        WR,
        RESP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              is_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] memout_q;
    logic [CNT_W-1:0]  cnt;
    logic              phase_last;
    logic              bus_act;
    logic              rd_i;
    logic [ADDR_W-1:0] ptr_val;

    assign phase_last = (cnt == CNT_LAST);

    // Fetched pointer: low ADDR_W bits of the word, zero-extended if narrower.
    generate
        if (DATA_W >= ADDR_W) begin : g_ptr_trunc
            assign ptr_val = DMem_dout[ADDR_W-1:0];
        end else begin : g_ptr_zext
            assign ptr_val = {{(ADDR_W - DATA_W){1'b0}}, DMem_dout};
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers. The counter is cleared on leaving each read phase
    // and while idle, so every phase starts counting from 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_write <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            memout_q <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        is_write <= req_op[1];
                        addr_q   <= req_addr;
                        data_q   <= req_data;
                    end
                end
                RD_PTR: begin
                    if (phase_last) begin
                        addr_q <= ptr_val;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_DATA: begin
                    if (phase_last) begin
                        memout_q <= DMem_dout;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    memout_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        DMem_en   = 1'b0;
        rd_i      = 1'b0;
        bus_act   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    case (req_op)
                        2'b00:   state_n = RD_DATA;
                        2'b10:   state_n = WR;
                        default: state_n = RD_PTR;
                    endcase
                end
            end
            RD_PTR: begin
                DMem_en = 1'b1;
                rd_i    = 1'b1;
                bus_act = 1'b1;
                if (phase_last) begin
                    state_n = is_write ? WR : RD_DATA;
                end
            end
            RD_DATA: begin
                DMem_en = 1'b1;
                rd_i    = 1'b1;
                bus_act = 1'b1;
                if (phase_last) begin
                    state_n = RESP;
                end
            end
            WR: begin
                DMem_en = 1'b1;
                bus_act = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign memout = memout_q;

`ifdef MEMACCESS_TRISTATE_EN
    assign DMem_addr = bus_act ? addr_q : {ADDR_W{1'bz}};
    assign DMem_din  = bus_act ? data_q : {DATA_W{1'bz}};
    assign DMem_rd   = bus_act ? rd_i : 1'bz;
`else
    assign DMem_addr = bus_act ? addr_q : '0;
    assign DMem_din  = bus_act ? data_q : '0;
    assign DMem_rd   = bus_act ? rd_i : 1'b0;
`endif

endmodule

// File: tb/tb_memaccess_unit.sv
// tb/tb_memaccess_unit.sv - self-checking bench for memaccess_unit with a latency-modelled data memory

module tb_memaccess_unit;

    localparam int RD_LAT = 3;

`ifdef MEMACCESS_TRISTATE_EN
    localparam logic [15:0] IDLE_W = 16'hzzzz;
    localparam logic        IDLE_B = 1'bz;
`else
    localparam logic [15:0] IDLE_W = 16'h0000;
    localparam logic        IDLE_B = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] memout;
    logic        busy;
    logic        DMem_en;
    logic        DMem_rd;
    logic [15:0] DMem_addr;
    logic [15:0] DMem_din;
    logic [15:0] DMem_dout;

    memaccess_unit #(.DATA_W(16), .ADDR_W(16), .RD_LAT(RD_LAT)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .memout(memout), .busy(busy),
        .DMem_en(DMem_en), .DMem_rd(DMem_rd), .DMem_addr(DMem_addr),
        .DMem_din(DMem_din), .DMem_dout(DMem_dout)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Memory model: unwritten words hold a hash of their address.
    logic [15:0] mem [65536];
    bit          wflag [65536];
    logic [15:0] ref_mem [65536];
    bit          ref_flag [65536];
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr, poke_data;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    logic [15:0] last_wr_addr = 16'h0, last_wr_din = 16'h0;
    logic [16:0] hist [RD_LAT];

    function automatic logic [15:0] hash(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    always @(posedge clock) begin
        hist[0] <= {(DMem_en === 1'b1 && DMem_rd === 1'b1), DMem_addr};
        for (int k = 1; k < RD_LAT; k++) hist[k] <= hist[k-1];
        if (DMem_en === 1'b1 && DMem_rd === 1'b1) rd_cycles <= rd_cycles + 1;
        if (DMem_en === 1'b1 && DMem_rd === 1'b0) begin
            wr_cycles    <= wr_cycles + 1;
            mem[DMem_addr]   <= DMem_din;
            wflag[DMem_addr] <= 1'b1;
            last_wr_addr <= DMem_addr;
            last_wr_din  <= DMem_din;
        end
        if (poke_en) begin
            mem[poke_addr]   <= poke_data;
            wflag[poke_addr] <= 1'b1;
        end
    end

    // Read data is valid only once the same read address has been held for RD_LAT cycles.
    always_comb begin
        logic ok;
        ok = (DMem_en === 1'b1 && DMem_rd === 1'b1);
        for (int k = 0; k < RD_LAT - 1; k++)
            if (hist[k] !== {1'b1, DMem_addr}) ok = 1'b0;
        DMem_dout = ok ? (wflag[DMem_addr] ? mem[DMem_addr] : hash(DMem_addr)) : 16'hDEAD;
    end

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_flag[a] ? ref_mem[a] : hash(a);
    endfunction

    task automatic ref_wr(input logic [15:0] a, input logic [15:0] d);
        ref_mem[a]  = d;
        ref_flag[a] = 1'b1;
    endtask

    // Reference: result, latency (edge at which rsp_valid is first sampled high,
    // counting the acceptance edge as 0), read-strobe cycles, write strobes, write address.
    task automatic ref_exec(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                            output logic [15:0] ed, output int el, output int erd,
                            output int ewr, output logic [15:0] ewa);
        logic [15:0] p;
        ewa = 16'h0;
        case (op)
            2'd0: begin ed = ref_rd(a); el = RD_LAT + 1; erd = RD_LAT; ewr = 0; end
            2'd1: begin p = ref_rd(a); ed = ref_rd(p); el = 2*RD_LAT + 1; erd = 2*RD_LAT; ewr = 0; end
            2'd2: begin ref_wr(a, d); ed = 16'h0; el = 2; erd = 0; ewr = 1; ewa = a; end
            default: begin
                p = ref_rd(a); ref_wr(p, d); ed = 16'h0; el = RD_LAT + 2; erd = RD_LAT; ewr = 1; ewa = p;
            end
        endcase
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        @(posedge clock);
        @(negedge clock);
        poke_en = 1'b0;
        ref_wr(a, d);
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d, output bit acc);
        req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready === 1'b1) begin acc = 1'b1; break; end
            @(negedge clock);
        end
        if (acc) @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (rsp_valid !== 1'b1) lat = -1;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] mo, output int nrd, output int nwr,
                          output logic [15:0] wa, output logic [15:0] wd);
        int rd0, wr0;
        bit acc;
        rd0 = rd_cycles; wr0 = wr_cycles;
        issue(op, a, d, acc);
        wait_rsp(lat);
        mo = memout;
        if (lat > 0) release_rsp();
        nrd = rd_cycles - rd0; nwr = wr_cycles - wr0;
        wa = last_wr_addr; wd = last_wr_din;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = 16'h0; req_data = 16'h0; rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (memout !== 16'h0) begin errors++; $display("FAIL rst_memout got=%h exp=0000", memout); end
        checks++; if (DMem_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", DMem_en); end
        checks++; if (DMem_addr !== IDLE_W || DMem_din !== IDLE_W || DMem_rd !== IDLE_B) begin
            errors++; $display("FAIL rst_bus got=%h/%h/%b exp=%h/%h/%b", DMem_addr, DMem_din, DMem_rd, IDLE_W, IDLE_W, IDLE_B);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_direct_read();
        int lat, nrd, nwr, el, erd, ewr;
        logic [15:0] mo, wa, wd, ed, ewa;
        poke(16'h3000, 16'hBEEF);
        ref_exec(2'd0, 16'h3000, 16'h0, ed, el, erd, ewr, ewa);
        run_op(2'd0, 16'h3000, 16'h0, lat, mo, nrd, nwr, wa, wd);
        checks++; if (lat != el) begin errors++; $display("FAIL rd_latency got=%0d exp=%0d", lat, el); end
        checks++; if (mo !== 16'hBEEF) begin errors++; $display("FAIL rd_data got=%h exp=beef", mo); end
        checks++; if (nrd != erd || nwr != ewr) begin errors++; $display("FAIL rd_strobes got=%0d/%0d exp=%0d/%0d", nrd, nwr, erd, ewr); end
    endtask

    task automatic test_indirect_read();
        int lat, nrd, nwr, el, erd, ewr;
        logic [15:0] mo, wa, wd, ed, ewa;
        poke(16'h4000, 16'h4100);
        poke(16'h4100, 16'h1234);
        ref_exec(2'd1, 16'h4000, 16'h0, ed, el, erd, ewr, ewa);
        run_op(2'd1, 16'h4000, 16'h0, lat, mo, nrd, nwr, wa, wd);
        checks++; if (lat != el) begin errors++; $display("FAIL rdi_latency got=%0d exp=%0d", lat, el); end
        checks++; if (mo !== 16'h1234) begin errors++; $display("FAIL rdi_data got=%h exp=1234", mo); end
        checks++; if (nrd != erd || nwr != 0) begin errors++; $display("FAIL rdi_strobes got=%0d/%0d exp=%0d/0", nrd, nwr, erd); end
    endtask

    task automatic test_indirect_write();
        int lat, nrd, nwr, el, erd, ewr;
        logic [15:0] mo, wa, wd, ed, ewa;
        poke(16'h5000, 16'h5008);
        ref_exec(2'd3, 16'h5000, 16'hCAFE, ed, el, erd, ewr, ewa);
        run_op(2'd3, 16'h5000, 16'hCAFE, lat, mo, nrd, nwr, wa, wd);
        checks++; if (lat != el) begin errors++; $display("FAIL wri_latency got=%0d exp=%0d", lat, el); end
        checks++; if (mo !== 16'h0) begin errors++; $display("FAIL wri_memout got=%h exp=0000", mo); end
        checks++; if (nwr != 1 || nrd != erd) begin errors++; $display("FAIL wri_strobes got=%0d/%0d exp=%0d/1", nrd, nwr, erd); end
        checks++; if (wa !== 16'h5008 || wd !== 16'hCAFE) begin errors++; $display("FAIL wri_target got=%h:%h exp=5008:cafe", wa, wd); end
        checks++; if (mem[16'h5000] !== 16'h5008) begin errors++; $display("FAIL wri_ptr_kept got=%h exp=5008", mem[16'h5000]); end
    endtask

    task automatic test_backpressure();
        int lat, rd0, wr0;
        bit acc;
        logic [15:0] mo, ed, ewa;
        int el, erd, ewr;
        poke(16'h3100, 16'h7777);
        ref_exec(2'd0, 16'h3100, 16'h0, ed, el, erd, ewr, ewa);
        issue(2'd0, 16'h3100, 16'h0, acc);
        wait_rsp(lat);
        mo = memout;
        checks++; if (mo !== ed) begin errors++; $display("FAIL bp_data got=%h exp=%h", mo, ed); end
        rd0 = rd_cycles; wr0 = wr_cycles;
        req_op = 2'd2; req_addr = 16'h3100; req_data = 16'h0BAD; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (rsp_valid !== 1'b1 || memout !== mo || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/%h/0", i, rsp_valid, memout, req_ready, mo);
            end
        end
        req_valid = 1'b0;
        checks++; if (rd_cycles != rd0 || wr_cycles != wr0) begin errors++; $display("FAIL bp_no_access got=%0d/%0d exp=0/0", rd_cycles-rd0, wr_cycles-wr0); end
        release_rsp();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b/%b exp=1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int lat, el, erd, ewr;
        bit acc;
        logic [15:0] dA, ed, ewa;
        dA = 16'($urandom);
        ref_exec(2'd2, 16'h3200, dA, ed, el, erd, ewr, ewa);
        issue(2'd2, 16'h3200, dA, acc);
        wait_rsp(lat);
        checks++; if (lat != el) begin errors++; $display("FAIL b2b_wr_latency got=%0d exp=%0d", lat, el); end
        req_op = 2'd0; req_addr = 16'h3200; req_data = 16'h0; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_gap got=%b/%b/%b exp=1/0/0", req_ready, busy, rsp_valid);
        end
        ref_exec(2'd0, 16'h3200, 16'h0, ed, el, erd, ewr, ewa);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        wait_rsp(lat);
        checks++; if (lat != el) begin errors++; $display("FAIL b2b_rd_latency got=%0d exp=%0d", lat, el); end
        checks++; if (memout !== ed) begin errors++; $display("FAIL b2b_rd_data got=%h exp=%h", memout, ed); end
        if (lat > 0) release_rsp();
    endtask

    task automatic test_reset_mid_op();
        int wr0;
        bit acc;
        poke(16'h5100, 16'h5108);
        wr0 = wr_cycles;
        issue(2'd3, 16'h5100, 16'h1111, acc);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || DMem_en !== 1'b0 || memout !== 16'h0) begin
            errors++; $display("FAIL mid_rst_outs got=%b/%b/%b/%h exp=0/0/0/0000", busy, rsp_valid, DMem_en, memout);
        end
        checks++; if (DMem_addr !== IDLE_W || DMem_rd !== IDLE_B) begin
            errors++; $display("FAIL mid_rst_bus got=%h/%b exp=%h/%b", DMem_addr, DMem_rd, IDLE_W, IDLE_B);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", req_ready); end
        repeat (10) @(negedge clock);
        checks++; if (wr_cycles != wr0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_no_write got=%0d/%b exp=0/0", wr_cycles - wr0, rsp_valid);
        end
        checks++; if (wflag[16'h5108] !== 1'b0) begin errors++; $display("FAIL mid_rst_mem got=%b exp=0", wflag[16'h5108]); end
    endtask

    task automatic test_idle_bus();
        @(negedge clock);
        checks++; if (DMem_en !== 1'b0 || DMem_addr !== IDLE_W || DMem_din !== IDLE_W || DMem_rd !== IDLE_B) begin
            errors++; $display("FAIL idle_bus got=%b/%h/%h/%b exp=0/%h/%h/%b", DMem_en, DMem_addr, DMem_din, DMem_rd, IDLE_W, IDLE_W, IDLE_B);
        end
    endtask

    task automatic test_random();
        int lat, nrd, nwr, el, erd, ewr;
        logic [15:0] mo, wa, wd, ed, ewa, a, d;
        logic [1:0] op;
        for (int i = 0; i < 16; i++) poke(16'h6000 + 16'(i), 16'h6000 + 16'($urandom_range(0, 15)));
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'h6000 + 16'($urandom_range(0, 15));
            d  = 16'($urandom);
            ref_exec(op, a, d, ed, el, erd, ewr, ewa);
            run_op(op, a, d, lat, mo, nrd, nwr, wa, wd);
            checks++;
            if (lat != el || mo !== ed || nrd != erd || nwr != ewr) begin
                errors++; $display("FAIL rand_op i=%0d op=%0d got lat=%0d data=%h rd=%0d wr=%0d exp lat=%0d data=%h rd=%0d wr=%0d",
                                   i, op, lat, mo, nrd, nwr, el, ed, erd, ewr);
            end
            if (ewr == 1) begin
                checks++;
                if (wa !== ewa || wd !== d) begin errors++; $display("FAIL rand_wr i=%0d got=%h:%h exp=%h:%h", i, wa, wd, ewa, d); end
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_idle_bus();
        test_direct_read();
        test_indirect_read();
        test_indirect_write();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        test_idle_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
